// File: rtl/hazard_ctrl_gen2.sv
// hazard_ctrl_gen2: pipeline hazard controller for a 5-stage core.
// Drives the PC enable plus a per-latch enable and flush for IF/ID, ID/EX,
// EX/MEM and MEM/WB. It handles these cases:
//   - load-use stalls, optionally lasting several cycles
//   - a no-forwarding mode that stalls on any RAW hazard against EX or MEM
//   - a data-memory freeze, guarded by a watchdog
//   - a saturating count of stall cycles
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ihit, dhit          fetch / data access complete this cycle
//   dmem_req, redirect  MEM stage holds a load/store, taken control transfer in EX
//   id_rs/id_rt, id_uses_rs/id_uses_rt   ID source registers and whether they are read
//   ex_wsel/mem_wsel, ex_wen/mem_wen     EX / MEM destination registers and write enables
//   ex_is_load          EX instruction is a load
//   clr_cnt             clear stall_cycles
//   pc_en, stage_en[3:0], stage_flush[3:0]   pipeline control (bit0 = IF/ID)
//   stall_cycles        saturating count of cycles with pc_en low
//   mem_timeout         sticky watchdog flag
module hazard_ctrl_gen2 #(
  parameter int REG_W       = 5,
  parameter int FWD_EN      = 1,
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             redirect,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic             ex_wen,
  input  logic             mem_wen,
  input  logic             ex_is_load,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic [3:0]       stage_en,
  output logic [3:0]       stage_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int FRZ_CLOG = $clog2(MEM_TIMEOUT + 1);
  localparam int FRZ_W    = (FRZ_CLOG > 8) ? FRZ_CLOG : 8;
  localparam logic [FRZ_W-1:0] FRZ_MAX = FRZ_W'(MEM_TIMEOUT);
  localparam logic [3:0] BUB_INIT = 4'(LU_BUBBLES - 1);
  // Extra bubble cycles only exist for a load-use stall with forwarding.
  localparam bit MULTI = (FWD_EN != 0) && (LU_BUBBLES > 1);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       bub_q, bub_d;
  logic [FRZ_W-1:0] frz_q;
  logic [FRZ_W-1:0] frz_inc;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;
  logic             hz_ex, hz_mem, hazard, freeze;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign hz_ex  = ex_wen && (ex_wsel != '0) &&
                  ((id_uses_rs && (id_rs == ex_wsel)) || (id_uses_rt && (id_rt == ex_wsel)));
  assign hz_mem = mem_wen && (mem_wsel != '0) &&
                  ((id_uses_rs && (id_rs == mem_wsel)) || (id_uses_rt && (id_rt == mem_wsel)));
  assign hazard = (FWD_EN != 0) ? (hz_ex && ex_is_load) : (hz_ex || hz_mem);
  assign freeze = dmem_req && !dhit;
  assign frz_inc = frz_q + 1'b1;

  assign stall_cycles = cnt_q;
  assign mem_timeout  = tmo_q;

  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    pc_en       = 1'b1;
    stage_en    = 4'b1111;
    stage_flush = 4'b0000;
    if (RST) begin
      pc_en       = 1'b0;
      stage_flush = 4'b1111;
    end else if (freeze) begin
      // The whole pipe holds. FSM state is untouched, so a bubble sequence resumes afterwards.
      pc_en    = 1'b0;
      stage_en = 4'b0000;
    end else if (redirect) begin
      // Squash the wrong-path IF/ID and ID/EX contents. Any pending bubble is moot.
      stage_flush = 4'b0011;
      state_d     = RUN;
      bub_d       = 4'd0;
    end else if (state_q == BUBBLE) begin
      pc_en       = 1'b0;
      stage_en    = 4'b1110;
      stage_flush = 4'b0010;
      bub_d       = bub_q - 4'd1;
      if (bub_q == 4'd1) state_d = RUN;
    end else if (hazard) begin
      // Hold the consumer in ID and inject a bubble into EX.
      pc_en       = 1'b0;
      stage_en    = 4'b1110;
      stage_flush = 4'b0010;
      if (MULTI) begin
        state_d = BUBBLE;
        bub_d   = BUB_INIT;
      end
    end else if (!ihit) begin
      pc_en       = 1'b0;
      stage_flush = 4'b0001;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      bub_q   <= 4'd0;
      frz_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if (freeze) begin
        // The freeze count stops at the limit. The flag stays sticky.
        if (frz_q != FRZ_MAX) begin
          frz_q <= frz_inc;
          if (frz_inc == FRZ_MAX) tmo_q <= 1'b1;
        end
      end else begin
        frz_q <= '0;
      end
      if (clr_cnt)                      cnt_q <= '0;
      else if (!pc_en && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
module tb_hazard_ctrl_gen2;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ihit, dhit, dmem_req, redirect, id_uses_rs, id_uses_rt;
  logic ex_wen, mem_wen, ex_is_load, clr_cnt;
  logic [4:0] id_rs, id_rt, ex_wsel, mem_wsel;

  // a: FWD=1 LU=1 | b: FWD=1 LU=3 MT=4 CNT_W=4 | c: FWD=0
  logic pa, pb, pcc, ta, tb, tc;
  logic [3:0] ea, eb, ec, fa, fb, fc, sb;
  logic [15:0] sa, sc;

  hazard_ctrl_gen2 #(.REG_W(5), .FWD_EN(1), .LU_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) u_a (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req), .redirect(redirect),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_wsel(ex_wsel), .mem_wsel(mem_wsel), .ex_wen(ex_wen), .mem_wen(mem_wen),
    .ex_is_load(ex_is_load), .clr_cnt(clr_cnt), .pc_en(pa), .stage_en(ea), .stage_flush(fa),
    .stall_cycles(sa), .mem_timeout(ta));
  hazard_ctrl_gen2 #(.REG_W(5), .FWD_EN(1), .LU_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(4)) u_b (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req), .redirect(redirect),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_wsel(ex_wsel), .mem_wsel(mem_wsel), .ex_wen(ex_wen), .mem_wen(mem_wen),
    .ex_is_load(ex_is_load), .clr_cnt(clr_cnt), .pc_en(pb), .stage_en(eb), .stage_flush(fb),
    .stall_cycles(sb), .mem_timeout(tb));
  hazard_ctrl_gen2 #(.REG_W(5), .FWD_EN(0), .LU_BUBBLES(1), .MEM_TIMEOUT(255), .CNT_W(16)) u_c (
    .CLK(clk), .RST(rst), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req), .redirect(redirect),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_wsel(ex_wsel), .mem_wsel(mem_wsel), .ex_wen(ex_wen), .mem_wen(mem_wen),
    .ex_is_load(ex_is_load), .clr_cnt(clr_cnt), .pc_en(pcc), .stage_en(ec), .stage_flush(fc),
    .stall_cycles(sc), .mem_timeout(tc));

  int checks = 0;
  int failures = 0;

  localparam logic [8:0] O_RST  = 9'b0_1111_1111;
  localparam logic [8:0] O_RUN  = 9'b1_1111_0000;
  localparam logic [8:0] O_STL  = 9'b0_1110_0010;
  localparam logic [8:0] O_FRZ  = 9'b0_0000_0000;
  localparam logic [8:0] O_RDR  = 9'b1_1111_0011;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; ihit = 1; dhit = 1; dmem_req = 0; redirect = 0; clr_cnt = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_wsel = 0; mem_wsel = 0; ex_wen = 0; mem_wen = 0; ex_is_load = 0;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_wen = 1; ex_wsel = 5; id_rs = 5; id_uses_rs = 1;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    set_lu(); #1; tick();
    idle(); #1;
    checks++;
    if ({pb, eb, fb} !== O_STL) begin failures++; $display("FAIL rst_pre_bubble got=%b exp=%b", {pb, eb, fb}, O_STL); end
    rst = 1; #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pa, ea, fa} !== O_RST || {pb, eb, fb} !== O_RST || {pcc, ec, fc} !== O_RST) begin
        failures++; $display("FAIL rst_outputs cyc=%0d got a=%b b=%b c=%b exp=%b", i, {pa, ea, fa}, {pb, eb, fb}, {pcc, ec, fc}, O_RST);
      end
      tick();
    end
    rst = 0; #1;
    checks++;
    if ({pb, eb, fb} !== O_RUN || sb !== 4'd0 || sa !== 16'd0 || tb !== 1'b0) begin
      failures++; $display("FAIL rst_release got=%b cnt=%0d to=%b exp=%b cnt=0 to=0", {pb, eb, fb}, sb, tb, O_RUN);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(); #1;
    checks++;
    if ({pa, ea, fa} !== O_STL) begin failures++; $display("FAIL lu_stall got=%b exp=%b", {pa, ea, fa}, O_STL); end
    tick(); idle(); #1;
    checks++;
    if ({pa, ea, fa} !== O_RUN) begin failures++; $display("FAIL lu_resume got=%b exp=%b", {pa, ea, fa}, O_RUN); end
    set_lu(); ex_wsel = 0; id_rs = 0; #1;
    checks++;
    if ({pa, ea, fa} !== O_RUN || {pcc, ec, fc} !== O_RUN) begin
      failures++; $display("FAIL lu_r0 got a=%b c=%b exp=%b", {pa, ea, fa}, {pcc, ec, fc}, O_RUN);
    end
    ex_wsel = 5; id_rs = 5; ex_is_load = 0; #1;
    checks++;
    if ({pa, ea, fa} !== O_RUN || {pcc, ec, fc} !== O_STL) begin
      failures++; $display("FAIL alu_dep got a=%b c=%b exp a=%b c=%b", {pa, ea, fa}, {pcc, ec, fc}, O_RUN, O_STL);
    end
    tick(); idle();
  endtask

  task automatic test_multi_bubble();
    logic [8:0] exp_seq [5];
    exp_seq = '{O_STL, O_FRZ, O_FRZ, O_STL, O_STL};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i == 0) set_lu();
      if (i == 1 || i == 2) begin dmem_req = 1; dhit = 0; end
      #1;
      checks++;
      if ({pb, eb, fb} !== exp_seq[i]) begin failures++; $display("FAIL mb_seq cyc=%0d got=%b exp=%b", i, {pb, eb, fb}, exp_seq[i]); end
      tick();
    end
    idle(); #1;
    checks++;
    if ({pb, eb, fb} !== O_RUN || sb !== 4'd5) begin
      failures++; $display("FAIL mb_end got=%b cnt=%0d exp=%b cnt=5", {pb, eb, fb}, sb, O_RUN);
    end
  endtask

  task automatic test_nofwd();
    do_reset();
    mem_wen = 1; mem_wsel = 7; id_rt = 7; id_uses_rt = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({pcc, ec, fc} !== O_STL || {pa, ea, fa} !== O_RUN) begin
        failures++; $display("FAIL nofwd_stall cyc=%0d got c=%b a=%b exp c=%b a=%b", i, {pcc, ec, fc}, {pa, ea, fa}, O_STL, O_RUN);
      end
      tick();
    end
    redirect = 1; #1;
    checks++;
    if ({pcc, ec, fc} !== O_RDR) begin failures++; $display("FAIL nofwd_redirect got=%b exp=%b", {pcc, ec, fc}, O_RDR); end
    tick(); idle(); #1;
    checks++;
    if ({pcc, ec, fc} !== O_RUN) begin failures++; $display("FAIL nofwd_after got=%b exp=%b", {pcc, ec, fc}, O_RUN); end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1; dhit = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (tb !== (i >= 4)) begin failures++; $display("FAIL tmo_edge edge=%0d got=%b exp=%b", i, tb, (i >= 4)); end
    end
    dhit = 1; tick(); idle(); tick();
    checks++;
    if (tb !== 1'b1 || ta !== 1'b0 || tc !== 1'b0) begin
      failures++; $display("FAIL tmo_sticky got b=%b a=%b c=%b exp b=1 a=0 c=0", tb, ta, tc);
    end
    rst = 1; tick(); rst = 0;
    checks++;
    if (tb !== 1'b0) begin failures++; $display("FAIL tmo_clear got=%b exp=0", tb); end
  endtask

  task automatic test_saturate();
    do_reset();
    ihit = 0;
    repeat (20) tick();
    checks++;
    if (sb !== 4'd15 || sa !== 16'd20) begin failures++; $display("FAIL sat got b=%0d a=%0d exp b=15 a=20", sb, sa); end
    clr_cnt = 1; tick(); clr_cnt = 0;
    checks++;
    if (sb !== 4'd0 || sa !== 16'd0) begin failures++; $display("FAIL clr got b=%0d a=%0d exp 0", sb, sa); end
    tick();
    checks++;
    if (sb !== 4'd1) begin failures++; $display("FAIL clr_resume got=%0d exp=1", sb); end
    idle();
  endtask

  // Reference model: bubbles still owed, consecutive freeze length, stall count.
  task automatic test_random();
    int fwd_k [3] = '{1, 1, 0};
    int lu_k  [3] = '{1, 3, 1};
    int mt_k  [3] = '{255, 4, 255};
    int max_k [3] = '{65535, 15, 65535};
    int left [3], frz [3], cnt [3];
    bit to [3];
    logic [8:0] exp_o [3];
    logic [8:0] got_o [3];
    int got_cnt [3];
    bit got_to [3];
    bit fz, hzx, hzm, hz;
    do_reset();
    for (int k = 0; k < 3; k++) begin left[k] = 0; frz[k] = 0; cnt[k] = 0; to[k] = 0; end
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      ihit = ($urandom_range(0, 4) != 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dhit = $urandom_range(0, 1);
      redirect = ($urandom_range(0, 9) == 0);
      clr_cnt = ($urandom_range(0, 19) == 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_wsel = 5'($urandom_range(0, 3)); mem_wsel = 5'($urandom_range(0, 3));
      id_uses_rs = $urandom_range(0, 1); id_uses_rt = $urandom_range(0, 1);
      ex_wen = $urandom_range(0, 1); mem_wen = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
      fz  = dmem_req && !dhit;
      hzx = ex_wen && ex_wsel != 0 && ((id_uses_rs && id_rs == ex_wsel) || (id_uses_rt && id_rt == ex_wsel));
      hzm = mem_wen && mem_wsel != 0 && ((id_uses_rs && id_rs == mem_wsel) || (id_uses_rt && id_rt == mem_wsel));
      #1;
      got_o[0] = {pa, ea, fa}; got_o[1] = {pb, eb, fb}; got_o[2] = {pcc, ec, fc};
      got_cnt[0] = int'(sa); got_cnt[1] = int'(sb); got_cnt[2] = int'(sc);
      got_to[0] = ta; got_to[1] = tb; got_to[2] = tc;
      for (int k = 0; k < 3; k++) begin
        hz = (fwd_k[k] != 0) ? (hzx && ex_is_load) : (hzx || hzm);
        if (rst)                   exp_o[k] = O_RST;
        else if (fz)               exp_o[k] = O_FRZ;
        else if (redirect)         exp_o[k] = O_RDR;
        else if (left[k] > 0 || hz) exp_o[k] = O_STL;
        else if (!ihit)            exp_o[k] = 9'b0_1111_0001;
        else                       exp_o[k] = O_RUN;
        checks++;
        if (got_o[k] !== exp_o[k] || got_cnt[k] != cnt[k] || got_to[k] != to[k]) begin
          failures++;
          $display("FAIL rand n=%0d inst=%0d got=%b cnt=%0d to=%b exp=%b cnt=%0d to=%b",
                   n, k, got_o[k], got_cnt[k], got_to[k], exp_o[k], cnt[k], to[k]);
        end
        if (rst) begin
          left[k] = 0; frz[k] = 0; cnt[k] = 0; to[k] = 0;
        end else begin
          if (fz) begin
            frz[k]++;
            if (frz[k] >= mt_k[k]) to[k] = 1;
          end else begin
            frz[k] = 0;
            if (redirect)                                  left[k] = 0;
            else if (left[k] > 0)                          left[k]--;
            else if (hz && fwd_k[k] != 0 && lu_k[k] > 1)   left[k] = lu_k[k] - 1;
          end
          if (clr_cnt)                                 cnt[k] = 0;
          else if (!exp_o[k][8] && cnt[k] < max_k[k])  cnt[k]++;
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1;
    tick(); tick();
    test_reset();
    test_load_use();
    test_multi_bubble();
    test_nofwd();
    test_timeout();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
